// File: rtl/xadc_chan_capture.sv
// XADC conversion-result capture: maps DRP results onto NCH channels with
// 2^k averaging, min/max hold, threshold alarms and a small register bus.
module xadc_chan_capture #(
  parameter int                 NCH     = 4,
  parameter int                 DW      = 12,
  parameter int                 CHW     = 5,
  parameter logic [NCH*CHW-1:0] CH_MAP  = {5'd25, 5'd17, 5'd16, 5'd24},
  parameter int                 AVG_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              smp_vld_i,
  input  logic [CHW-1:0]    smp_ch_i,
  input  logic [15:0]       smp_dat_i,
  output logic [NCH*DW-1:0] val_o,
  output logic [NCH-1:0]    stb_o,
  output logic [NCH-1:0]    alarm_o,
  input  logic [31:0]       sys_addr_i,
  input  logic [31:0]       sys_wdata_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  output logic [31:0]       sys_rdata_o,
  output logic              sys_ack_o,
  output logic              sys_err_o
);

  localparam int AW   = DW + AVG_MAX;
  localparam int CNTW = AVG_MAX + 1;

  logic [DW-1:0]   val_q [NCH], val_d [NCH];
  logic [DW-1:0]   hi_q  [NCH], hi_d  [NCH];
  logic [DW-1:0]   lo_q  [NCH], lo_d  [NCH];
  logic [DW-1:0]   min_q [NCH], min_d [NCH];
  logic [DW-1:0]   max_q [NCH], max_d [NCH];
  logic [AW-1:0]   acc_q [NCH], acc_d [NCH];
  logic [CNTW-1:0] cnt_q [NCH], cnt_d [NCH];
  logic [2:0]      k_q   [NCH], k_d   [NCH];
  logic [NCH-1:0]  en_q, en_d, sticky_q, sticky_d;
  logic [NCH-1:0]  stb_q, stb_d, alarm_q, alarm_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;

  logic            sel_vld;
  int unsigned     sel_idx;
  logic [DW-1:0]   raw;
  logic [3:0]      bus_ch, bus_reg;
  logic            addr_ok, wr_sel, accept, new_alarm;
  logic [2:0]      k_eff;
  logic [CNTW-1:0] term;
  logic [AW-1:0]   sum, shifted;
  logic [DW-1:0]   new_val;
  logic            unused_bits;

  assign raw     = smp_dat_i[15 -: DW];
  assign bus_ch  = sys_addr_i[7:4];
  assign bus_reg = sys_addr_i[3:0];
  assign addr_ok = (sys_addr_i[19:8] == '0);
  assign unused_bits = ^{sys_addr_i[31:20], sys_wdata_i, smp_dat_i};

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!sel_vld && smp_ch_i == CH_MAP[i*CHW +: CHW]) begin
        sel_vld = 1'b1;
        sel_idx = i;
      end
    end
  end

  always_comb begin
    val_d    = val_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    min_d    = min_q;
    max_d    = max_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    en_d     = en_q;
    sticky_d = sticky_q;
    alarm_d  = alarm_q;
    stb_d    = '0;
    rdata_d  = '0;
    ack_d    = sys_wen_i | sys_ren_i;
    wr_sel    = 1'b0;
    accept    = 1'b0;
    new_alarm = 1'b0;
    k_eff     = '0;
    term      = '0;
    sum       = '0;
    shifted   = '0;
    new_val   = '0;

    for (int unsigned i = 0; i < NCH; i++) begin
      wr_sel = sys_wen_i && addr_ok && (bus_ch == 4'(i));

      // Register writes are applied first so a coincident publish layers on
      // top: min/max re-arm then take the new value, and a rising alarm
      // overrides the sticky clear.
      if (wr_sel) begin
        case (bus_reg)
          4'h0: if (sys_wdata_i[31]) sticky_d[i] = 1'b0;
          4'h4: begin
            k_d[i]   = sys_wdata_i[2:0];
            en_d[i]  = sys_wdata_i[8];
            acc_d[i] = '0;
            cnt_d[i] = '0;
          end
          4'h8: begin
            hi_d[i] = sys_wdata_i[DW-1:0];
            lo_d[i] = sys_wdata_i[16 +: DW];
          end
          4'hC: begin
            min_d[i] = '1;
            max_d[i] = '0;
          end
          default: ;
        endcase
      end

      accept = smp_vld_i && sel_vld && (sel_idx == i) && en_q[i]
               && !(wr_sel && bus_reg == 4'h4);
      k_eff  = (k_q[i] > 3'(AVG_MAX)) ? 3'(AVG_MAX) : k_q[i];
      term   = CNTW'((32'd1 << k_eff) - 32'd1);
      sum    = acc_q[i] + AW'(raw);

      if (accept) begin
        if (cnt_q[i] == term) begin
          shifted    = sum >> k_eff;
          new_val    = shifted[DW-1:0];
          new_alarm  = (new_val > hi_q[i]) || (new_val < lo_q[i]);
          val_d[i]   = new_val;
          stb_d[i]   = 1'b1;
          alarm_d[i] = new_alarm;
          if (new_alarm && !alarm_q[i]) sticky_d[i] = 1'b1;
          if (new_val < min_d[i]) min_d[i] = new_val;
          if (new_val > max_d[i]) max_d[i] = new_val;
          acc_d[i] = '0;
          cnt_d[i] = '0;
        end else begin
          acc_d[i] = sum;
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      if (sys_ren_i && addr_ok && (bus_ch == 4'(i))) begin
        case (bus_reg)
          4'h0: begin
            rdata_d[DW-1:0] = val_q[i];
            rdata_d[31]     = sticky_q[i];
          end
          4'h4: begin
            rdata_d[2:0] = k_q[i];
            rdata_d[8]   = en_q[i];
          end
          4'h8: begin
            rdata_d[DW-1:0]  = hi_q[i];
            rdata_d[16 +: DW] = lo_q[i];
          end
          4'hC: begin
            rdata_d[DW-1:0]  = min_q[i];
            rdata_d[16 +: DW] = max_q[i];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        val_q[i] <= '0;
        hi_q[i]  <= '1;
        lo_q[i]  <= '0;
        min_q[i] <= '1;
        max_q[i] <= '0;
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        k_q[i]   <= '0;
      end
      en_q     <= '1;
      sticky_q <= '0;
      stb_q    <= '0;
      alarm_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      val_q    <= val_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      min_q    <= min_d;
      max_q    <= max_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      en_q     <= en_d;
      sticky_q <= sticky_d;
      stb_q    <= stb_d;
      alarm_q  <= alarm_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    val_o = '0;
    for (int unsigned i = 0; i < NCH; i++) val_o[i*DW +: DW] = val_q[i];
  end

  assign stb_o       = stb_q;
  assign alarm_o     = alarm_q;
  assign sys_rdata_o = rdata_q;
  assign sys_ack_o   = ack_q;
  assign sys_err_o   = 1'b0;

endmodule

// File: tb/tb_xadc_chan_capture.sv
// Directed self-checking bench for xadc_chan_capture (default parameters).
module tb_xadc_chan_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smp_vld = 1'b0;
  logic [4:0]  smp_ch = '0;
  logic [15:0] smp_dat = '0;
  logic [47:0] val_o;
  logic [3:0]  stb_o, alarm_o;
  logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata_o;
  logic        sys_wen = 1'b0, sys_ren = 1'b0, sys_ack_o, sys_err_o;

  int tests = 0;
  int fails = 0;

  xadc_chan_capture #(
    .NCH(4), .DW(12), .CHW(5), .CH_MAP({5'd25, 5'd17, 5'd16, 5'd24}), .AVG_MAX(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .smp_vld_i(smp_vld), .smp_ch_i(smp_ch), .smp_dat_i(smp_dat),
    .val_o(val_o), .stb_o(stb_o), .alarm_o(alarm_o),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata),
    .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
    .sys_rdata_o(sys_rdata_o), .sys_ack_o(sys_ack_o), .sys_err_o(sys_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sys_wen = 1'b1; sys_addr = a; sys_wdata = d;
    @(negedge clk);
    sys_wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic ack);
    @(negedge clk);
    sys_ren = 1'b1; sys_addr = a;
    @(negedge clk);
    sys_ren = 1'b0;
    d = sys_rdata_o;
    ack = sys_ack_o;
  endtask

  task automatic smp(input logic [4:0] ch, input logic [15:0] d);
    @(negedge clk);
    smp_vld = 1'b1; smp_ch = ch; smp_dat = d;
    @(negedge clk);
    smp_vld = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic ack;
    tests++; if (val_o !== 48'h0) begin fails++; $display("FAIL rst_val: got %h exp 0", val_o); end
    tests++; if (stb_o !== 4'h0) begin fails++; $display("FAIL rst_stb: got %h exp 0", stb_o); end
    tests++; if (alarm_o !== 4'h0) begin fails++; $display("FAIL rst_alarm: got %h exp 0", alarm_o); end
    tests++; if (sys_ack_o !== 1'b0 || sys_rdata_o !== 32'h0) begin fails++; $display("FAIL rst_bus: got ack %b rdata %h exp 0/0", sys_ack_o, sys_rdata_o); end
    tests++; if (sys_err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", sys_err_o); end
    bus_rd(32'h04, rd, ack);
    tests++; if (rd !== 32'h100 || ack !== 1'b1) begin fails++; $display("FAIL rst_ctrl: got %h ack %b exp 00000100 ack 1", rd, ack); end
    bus_rd(32'h38, rd, ack);
    tests++; if (rd !== 32'hFFF) begin fails++; $display("FAIL rst_thr: got %h exp 00000fff", rd); end
    bus_rd(32'h2C, rd, ack);
    tests++; if (rd !== 32'hFFF) begin fails++; $display("FAIL rst_minmax: got %h exp 00000fff", rd); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    smp_vld = 1'b1; smp_ch = 5'd24; smp_dat = 16'hABC0;
    @(negedge clk);
    tests++; if (stb_o !== 4'b0001 || val_o[11:0] !== 12'hABC) begin fails++; $display("FAIL pass_ch0: got stb %b val %h exp 0001 abc", stb_o, val_o[11:0]); end
    smp_ch = 5'd16; smp_dat = 16'h1230;
    @(negedge clk);
    smp_vld = 1'b0;
    tests++; if (stb_o !== 4'b0010 || val_o[23:12] !== 12'h123) begin fails++; $display("FAIL pass_ch1: got stb %b val %h exp 0010 123", stb_o, val_o[23:12]); end
    tests++; if (val_o !== 48'h000_000_123_ABC) begin fails++; $display("FAIL pass_vals: got %h exp 000000123abc", val_o); end
    smp(5'd3, 16'hFFF0);
    tests++; if (stb_o !== 4'b0000 || val_o !== 48'h000_000_123_ABC) begin fails++; $display("FAIL pass_unmapped: got stb %b val %h exp 0000 000000123abc", stb_o, val_o); end
  endtask

  task automatic test_average();
    logic [3:0] seen = '0;
    bus_wr(32'h04, 32'h102);
    smp(5'd24, 16'h0010); seen |= stb_o;
    smp(5'd24, 16'h0020); seen |= stb_o;
    smp(5'd24, 16'h0030); seen |= stb_o;
    tests++; if (seen !== 4'b0000) begin fails++; $display("FAIL avg_early: got strobes %b exp 0000", seen); end
    smp(5'd24, 16'h0050);
    tests++; if (stb_o !== 4'b0001 || val_o[11:0] !== 12'h002) begin fails++; $display("FAIL avg_pub: got stb %b val %h exp 0001 002", stb_o, val_o[11:0]); end
  endtask

  task automatic test_alarm();
    logic [31:0] rd;
    logic ack;
    bus_wr(32'h18, 32'h0100_0800);
    smp(5'd16, 16'h9000);
    tests++; if (alarm_o[1] !== 1'b1 || stb_o !== 4'b0010) begin fails++; $display("FAIL alm_hi: got alarm %b stb %b exp 1 0010", alarm_o[1], stb_o); end
    bus_rd(32'h10, rd, ack);
    tests++; if (rd !== 32'h8000_0900) begin fails++; $display("FAIL alm_sticky: got %h exp 80000900", rd); end
    smp(5'd16, 16'h4000);
    bus_rd(32'h10, rd, ack);
    tests++; if (alarm_o[1] !== 1'b0 || rd !== 32'h8000_0400) begin fails++; $display("FAIL alm_clear: got alarm %b reg %h exp 0 80000400", alarm_o[1], rd); end
    bus_wr(32'h10, 32'h8000_0000);
    bus_rd(32'h10, rd, ack);
    tests++; if (rd !== 32'h0000_0400) begin fails++; $display("FAIL alm_w1c: got %h exp 00000400", rd); end
    smp(5'd16, 16'h8000);
    tests++; if (alarm_o[1] !== 1'b0) begin fails++; $display("FAIL alm_eq_hi: got %b exp 0", alarm_o[1]); end
    smp(5'd16, 16'h0FF0);
    tests++; if (alarm_o[1] !== 1'b1) begin fails++; $display("FAIL alm_lo: got %b exp 1", alarm_o[1]); end
    smp(5'd16, 16'h1000);
    tests++; if (alarm_o[1] !== 1'b0) begin fails++; $display("FAIL alm_eq_lo: got %b exp 0", alarm_o[1]); end
    bus_wr(32'h10, 32'h8000_0000);
    @(negedge clk);
    sys_wen = 1'b1; sys_addr = 32'h10; sys_wdata = 32'h8000_0000;
    smp_vld = 1'b1; smp_ch = 5'd16; smp_dat = 16'h9000;
    @(negedge clk);
    sys_wen = 1'b0; smp_vld = 1'b0;
    bus_rd(32'h10, rd, ack);
    tests++; if (rd !== 32'h8000_0900) begin fails++; $display("FAIL alm_set_wins: got %h exp 80000900", rd); end
  endtask

  task automatic test_minmax();
    logic [31:0] rd;
    logic ack;
    smp(5'd17, 16'h3000);
    smp(5'd17, 16'h0500);
    smp(5'd17, 16'h7FF0);
    bus_rd(32'h2C, rd, ack);
    tests++; if (rd !== 32'h07FF_0050) begin fails++; $display("FAIL mm_hold: got %h exp 07ff0050", rd); end
    @(negedge clk);
    sys_wen = 1'b1; sys_addr = 32'h2C; sys_wdata = 32'h0;
    smp_vld = 1'b1; smp_ch = 5'd17; smp_dat = 16'h2000;
    @(negedge clk);
    sys_wen = 1'b0; smp_vld = 1'b0;
    tests++; if (val_o[35:24] !== 12'h200 || stb_o !== 4'b0100) begin fails++; $display("FAIL mm_pub: got val %h stb %b exp 200 0100", val_o[35:24], stb_o); end
    bus_rd(32'h2C, rd, ack);
    tests++; if (rd !== 32'h0200_0200) begin fails++; $display("FAIL mm_rearm: got %h exp 02000200", rd); end
  endtask

  task automatic test_ctrl_collision();
    logic [31:0] rd;
    logic ack;
    logic [3:0] seen = '0;
    bus_wr(32'h04, 32'h103);
    for (int i = 0; i < 5; i++) begin
      smp(5'd24, 16'hFFF0);
      seen |= stb_o;
    end
    tests++; if (seen !== 4'b0000) begin fails++; $display("FAIL col_k3: got strobes %b exp 0000", seen); end
    @(negedge clk);
    sys_wen = 1'b1; sys_addr = 32'h04; sys_wdata = 32'h101;
    smp_vld = 1'b1; smp_ch = 5'd24; smp_dat = 16'hFFF0;
    @(negedge clk);
    sys_wen = 1'b0; smp_vld = 1'b0;
    tests++; if (stb_o !== 4'b0000) begin fails++; $display("FAIL col_drop: got stb %b exp 0000", stb_o); end
    smp(5'd24, 16'h1000);
    tests++; if (stb_o !== 4'b0000) begin fails++; $display("FAIL col_first: got stb %b exp 0000", stb_o); end
    smp(5'd24, 16'h3000);
    tests++; if (stb_o !== 4'b0001 || val_o[11:0] !== 12'h200) begin fails++; $display("FAIL col_mean: got stb %b val %h exp 0001 200", stb_o, val_o[11:0]); end
    bus_rd(32'h04, rd, ack);
    tests++; if (rd !== 32'h101) begin fails++; $display("FAIL col_ctrl: got %h exp 00000101", rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    logic ack;
    logic [3:0] seen = '0;
    bus_wr(32'h04, 32'h102);
    smp(5'd24, 16'h1000);
    smp(5'd24, 16'h1000);
    tests++; if (alarm_o[1] !== 1'b1) begin fails++; $display("FAIL ar_pre_alarm: got %b exp 1", alarm_o[1]); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (val_o !== 48'h0 || stb_o !== 4'h0 || alarm_o !== 4'h0) begin fails++; $display("FAIL ar_outputs: got val %h stb %b alarm %b exp 0", val_o, stb_o, alarm_o); end
    @(negedge clk);
    rst = 1'b0;
    bus_rd(32'h04, rd, ack);
    tests++; if (rd !== 32'h100) begin fails++; $display("FAIL ar_ctrl: got %h exp 00000100", rd); end
    bus_rd(32'h18, rd, ack);
    tests++; if (rd !== 32'hFFF) begin fails++; $display("FAIL ar_thr: got %h exp 00000fff", rd); end
    bus_rd(32'h10, rd, ack);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ar_sticky: got %h exp 0", rd); end
    bus_rd(32'h2C, rd, ack);
    tests++; if (rd !== 32'hFFF) begin fails++; $display("FAIL ar_minmax: got %h exp 00000fff", rd); end
    bus_wr(32'h04, 32'h102);
    smp(5'd24, 16'h0040); seen |= stb_o;
    smp(5'd24, 16'h0040); seen |= stb_o;
    smp(5'd24, 16'h0040); seen |= stb_o;
    tests++; if (seen !== 4'b0000) begin fails++; $display("FAIL ar_early: got strobes %b exp 0000", seen); end
    smp(5'd24, 16'h0080);
    tests++; if (stb_o !== 4'b0001 || val_o[11:0] !== 12'h005) begin fails++; $display("FAIL ar_first: got stb %b val %h exp 0001 005", stb_o, val_o[11:0]); end
    bus_rd(32'h50, rd, ack);
    tests++; if (ack !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL unmapped_ch: got ack %b rdata %h exp 1 0", ack, rd); end
    bus_rd(32'h104, rd, ack);
    tests++; if (ack !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL unmapped_hi: got ack %b rdata %h exp 1 0", ack, rd); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_average();
    test_alarm();
    test_minmax();
    test_ctrl_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
